// File: rtl/mips_pkg.sv
// Shared MIPS-R2000 pipeline definitions: opcode constants, the NOP word,
// the fetch FSM state type and the PC increment.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;

    localparam logic [31:0] NOP_INST = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {inst, pc} skid buffer. Catches a memory response that lands
// while the pipeline is stalled so the request does not have to be replayed.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        unload,
    input  logic        clear,
    input  logic [31:0] inst_in,
    input  logic [31:0] pc_in,
    output logic        full,
    output logic [31:0] inst,
    output logic [31:0] pc
);

    logic        full_q, full_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q,   pc_d;

    // Next entry contents: clear wins, then unload, then load.
    always_comb begin
        full_d = full_q;
        inst_d = inst_q;
        pc_d   = pc_q;
        if (clear) begin
            full_d = 1'b0;
            inst_d = NOP_INST;
            pc_d   = '0;
        end else if (unload) begin
            full_d = 1'b0;
        end else if (load) begin
            full_d = 1'b1;
            inst_d = inst_in;
            pc_d   = pc_in;
        end
    end

    // Entry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            inst_q <= NOP_INST;
            pc_q   <= '0;
        end else begin
            full_q <= full_d;
            inst_q <= inst_d;
            pc_q   <= pc_d;
        end
    end

    assign full = full_q;
    assign inst = inst_q;
    assign pc   = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS-R2000 instruction fetch stage: owns the PC, issues single-outstanding
// instruction memory requests and holds the IF/ID register.
// Optional feature macro: FETCH_JUMP_EN (fetch resolves J-type jumps itself).
//
// state | meaning
// FETCH | request outstanding at PC; IF/ID loads response or a bubble
// FULL  | response caught during a stall sits in the skid buffer; no request
// DRAIN | redirect taken with request in flight; wait for ack, discard it
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_pc,
    input  logic        hold_if,
    input  logic        br,
    input  logic [31:0] pc_branch,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pc,
    output logic        flush_id
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fpc_q, fpc_d;
    logic [31:0]  redir_q, redir_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  ifid_pc_q, ifid_pc_d;
    logic         flush_q, flush_d;

    logic         stall;
    logic         jump;
    logic         redirect;
    logic [31:0]  br_tgt;
    logic [31:0]  jump_tgt;
    logic [31:0]  target;
    logic [31:0]  fpc_next;

    logic         skid_load, skid_unload, skid_clear, skid_full;
    logic [31:0]  skid_inst, skid_pc;

    // Low target bits are forced to zero, never used.
    logic         unused_br_lsbs;
    assign unused_br_lsbs = ^pc_branch[1:0];

    assign stall    = hold_pc | hold_if;
    assign br_tgt   = {pc_branch[31:2], 2'b00};
    assign fpc_next = fpc_q + PC_STEP;

`ifdef FETCH_JUMP_EN
    // A J sitting in a valid IF/ID slot redirects fetch; ifid_pc is already PC+4.
    assign jump     = (inst_q[31:26] == OP_J) && !flush_q;
    assign jump_tgt = {ifid_pc_q[31:28], inst_q[25:0], 2'b00};
`else
    assign jump     = 1'b0;
    assign jump_tgt = '0;
`endif

    // Branch from decode wins over a jump seen in IF/ID.
    assign redirect = (br | jump) & ~stall;
    assign target   = br ? br_tgt : jump_tgt;

    // Request side depends only on registered state.
    assign imem_req  = (state_q != FULL);
    assign imem_addr = fpc_q;

    fetch_skid_buf u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .unload  (skid_unload),
        .clear   (skid_clear),
        .inst_in (imem_rdata),
        .pc_in   (fpc_next),
        .full    (skid_full),
        .inst    (skid_inst),
        .pc      (skid_pc)
    );

    // Next-state, PC and IF/ID update.
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        redir_d     = redir_q;
        inst_d      = inst_q;
        ifid_pc_d   = ifid_pc_q;
        flush_d     = flush_q;
        skid_load   = 1'b0;
        skid_unload = 1'b0;
        skid_clear  = 1'b0;

        case (state_q)
            FETCH: begin
                if (stall) begin
                    if (imem_ack) begin
                        skid_load = 1'b1;
                        fpc_d     = fpc_next;
                        state_d   = FULL;
                    end
                end else if (redirect) begin
                    inst_d  = NOP_INST;
                    flush_d = 1'b1;
                    if (imem_ack) begin
                        fpc_d = target;
                    end else begin
                        redir_d = target;
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    inst_d    = imem_rdata;
                    ifid_pc_d = fpc_next;
                    flush_d   = 1'b0;
                    fpc_d     = fpc_next;
                end else begin
                    inst_d  = NOP_INST;
                    flush_d = 1'b1;
                end
            end

            FULL: begin
                if (!stall) begin
                    if (redirect) begin
                        skid_clear = 1'b1;
                        inst_d     = NOP_INST;
                        flush_d    = 1'b1;
                        fpc_d      = target;
                    end else begin
                        if (skid_full) begin
                            inst_d    = skid_inst;
                            ifid_pc_d = skid_pc;
                            flush_d   = 1'b0;
                        end
                        skid_unload = 1'b1;
                    end
                    state_d = FETCH;
                end
            end

            DRAIN: begin
                if (!stall) begin
                    inst_d  = NOP_INST;
                    flush_d = 1'b1;
                end
                if (redirect) begin
                    redir_d = target;
                end
                // The abandoned access completes even under a stall; its data
                // is discarded, so moving to the saved target is always safe.
                if (imem_ack) begin
                    fpc_d   = redirect ? target : redir_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC, redirect and IF/ID registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            fpc_q     <= RESET_PC;
            redir_q   <= '0;
            inst_q    <= NOP_INST;
            ifid_pc_q <= '0;
            flush_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            redir_q   <= redir_d;
            inst_q    <= inst_d;
            ifid_pc_q <= ifid_pc_d;
            flush_q   <= flush_d;
        end
    end

    assign inst_out = inst_q;
    assign pc       = ifid_pc_q;
    assign flush_id = flush_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: per-cycle vector tables for the
// directed corner cases, then random stall/branch/ack traffic checked
// against an instruction-stream model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hold_pc = 1'b0;
    logic        hold_if = 1'b0;
    logic        br = 1'b0;
    logic [31:0] pc_branch = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst_out;
    logic [31:0] pc;
    logic        flush_id;

    int tests = 0;
    int fails = 0;
    logic j_phase = 1'b0;

    typedef struct {
        logic        hold_pc;
        logic        hold_if;
        logic        br;
        logic [31:0] pc_branch;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[$];

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold_pc    (hold_pc),
        .hold_if    (hold_if),
        .br         (br),
        .pc_branch  (pc_branch),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_out   (inst_out),
        .pc         (pc),
        .flush_id   (flush_id)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: an ADDI-opcode word that encodes its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (j_phase && a == 32'h0000_0100) return 32'h0800_0040;
        return {6'b001000, a[27:2]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic hp, input logic hi, input logic b, input logic [31:0] bt,
                       input logic ack, input logic er, input logic [31:0] ea,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ef);
        vec_t v;
        v.hold_pc = hp; v.hold_if = hi; v.br = b; v.pc_branch = bt; v.ack = ack;
        v.exp_req = er; v.exp_addr = ea; v.exp_inst = ei; v.exp_pc = ep; v.exp_flush = ef;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; hold_pc = 0; hold_if = 0; br = 0; pc_branch = '0; imem_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'b0, imem_req}, 32'd1);
        check("rst_addr",  imem_addr, RST_PC);
        check("rst_inst",  inst_out, 32'h0);
        check("rst_pc",    pc, 32'h0);
        check("rst_flush", {31'b0, flush_id}, 32'd1);
        rst_n = 1'b1;
    endtask

    task automatic run_table();
        foreach (vecs[i]) begin
            hold_pc   = vecs[i].hold_pc;
            hold_if   = vecs[i].hold_if;
            br        = vecs[i].br;
            pc_branch = vecs[i].pc_branch;
            imem_ack  = vecs[i].ack;
            imem_rdata = mem_word(imem_addr);
            check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
            check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_inst", i), inst_out, vecs[i].exp_inst);
            check($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("v%0d_flush", i), {31'b0, flush_id}, {31'b0, vecs[i].exp_flush});
        end
        vecs.delete();
        hold_pc = 0; hold_if = 0; br = 0; imem_ack = 0;
    endtask

    initial begin
        logic [31:0] exp_next;
        logic [31:0] prev_addr;
        logic [31:0] tgt;
        logic        prev_req, prev_ack, cur_stall, cur_br;
        int          deliveries;

        // Phase 1: streaming, stall into skid buffer, branch drain, wrap, branch from FULL.
        do_reset();
        //  hp hi br target        ack req addr           inst                       pc             flush
        add(0, 0, 0, 32'h0,        1,  1, 32'h100,        mem_word(32'h100),         32'h104,       0);
        add(0, 0, 0, 32'h0,        1,  1, 32'h104,        mem_word(32'h104),         32'h108,       0);
        add(1, 0, 0, 32'h0,        1,  1, 32'h108,        mem_word(32'h104),         32'h108,       0);
        add(1, 0, 0, 32'h0,        0,  0, 32'h10C,        mem_word(32'h104),         32'h108,       0);
        add(1, 0, 0, 32'h0,        0,  0, 32'h10C,        mem_word(32'h104),         32'h108,       0);
        add(0, 0, 0, 32'h0,        0,  0, 32'h10C,        mem_word(32'h108),         32'h10C,       0);
        add(0, 0, 0, 32'h0,        1,  1, 32'h10C,        mem_word(32'h10C),         32'h110,       0);
        add(0, 0, 1, 32'h203,      0,  1, 32'h110,        32'h0,                     32'h110,       1);
        add(0, 0, 0, 32'h0,        0,  1, 32'h110,        32'h0,                     32'h110,       1);
        add(0, 0, 0, 32'h0,        1,  1, 32'h110,        32'h0,                     32'h110,       1);
        add(0, 0, 0, 32'h0,        1,  1, 32'h200,        mem_word(32'h200),         32'h204,       0);
        add(1, 0, 1, 32'h400,      0,  1, 32'h204,        mem_word(32'h200),         32'h204,       0);
        add(0, 0, 0, 32'h0,        1,  1, 32'h204,        mem_word(32'h204),         32'h208,       0);
        add(0, 0, 1, 32'hFFFFFFFF, 1,  1, 32'h208,        32'h0,                     32'h208,       1);
        add(0, 0, 0, 32'h0,        1,  1, 32'hFFFFFFFC,   mem_word(32'hFFFFFFFC),    32'h0,         0);
        add(0, 0, 0, 32'h0,        1,  1, 32'h0,          mem_word(32'h0),           32'h4,         0);
        add(0, 0, 0, 32'h0,        0,  1, 32'h4,          32'h0,                     32'h4,         1);
        add(0, 1, 0, 32'h0,        1,  1, 32'h4,          32'h0,                     32'h4,         1);
        add(0, 0, 1, 32'h300,      0,  0, 32'h8,          32'h0,                     32'h4,         1);
        add(0, 0, 0, 32'h0,        1,  1, 32'h300,        mem_word(32'h300),         32'h304,       0);
        run_table();

        // Phase 2: J word at 0x100, then enter DRAIN and reset out of it.
        j_phase = 1'b1;
        do_reset();
        add(0, 0, 0, 32'h0,   1, 1, 32'h100, 32'h0800_0040,     32'h104, 0);
`ifdef FETCH_JUMP_EN
        add(0, 0, 0, 32'h0,   1, 1, 32'h104, 32'h0,             32'h104, 1);
        add(0, 0, 0, 32'h0,   1, 1, 32'h100, 32'h0800_0040,     32'h104, 0);
        add(0, 0, 1, 32'h500, 0, 1, 32'h104, 32'h0,             32'h104, 1);
        add(0, 0, 0, 32'h0,   0, 1, 32'h104, 32'h0,             32'h104, 1);
`else
        add(0, 0, 0, 32'h0,   1, 1, 32'h104, mem_word(32'h104), 32'h108, 0);
        add(0, 0, 0, 32'h0,   1, 1, 32'h108, mem_word(32'h108), 32'h10C, 0);
        add(0, 0, 1, 32'h500, 0, 1, 32'h10C, 32'h0,             32'h10C, 1);
        add(0, 0, 0, 32'h0,   0, 1, 32'h10C, 32'h0,             32'h10C, 1);
`endif
        run_table();
        j_phase = 1'b0;

        // Phase 3: random traffic against the instruction-stream model.
        do_reset();
        exp_next = RST_PC;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        deliveries = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(99) < 20) begin
                hold_pc = $urandom_range(1);
                hold_if = ~hold_pc | $urandom_range(1);
            end else begin
                hold_pc = 1'b0;
                hold_if = 1'b0;
            end
            br        = ($urandom_range(99) < 6);
            pc_branch = $urandom;
            imem_ack  = imem_req && ($urandom_range(99) < 60);
            imem_rdata = mem_word(imem_addr);

            if (prev_req && !prev_ack) begin
                check("req_held", {31'b0, imem_req}, 32'd1);
                check("addr_held", imem_addr, prev_addr);
            end
            if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);

            prev_req  = imem_req;
            prev_ack  = imem_ack;
            prev_addr = imem_addr;
            cur_stall = hold_pc | hold_if;
            cur_br    = br & ~cur_stall;
            tgt       = {pc_branch[31:2], 2'b00};

            @(posedge clk);
            #1;
            if (flush_id) check("bubble_nop", inst_out, 32'h0);
            if (cur_br) begin
                exp_next = tgt;
            end else if (!cur_stall && !flush_id) begin
                deliveries++;
                check("deliv_pc", pc - 32'd4, exp_next);
                check("deliv_inst", inst_out, mem_word(pc - 32'd4));
                exp_next = pc;
`ifdef FETCH_JUMP_EN
                if (inst_out[31:26] == 6'b000010)
                    exp_next = {pc[31:28], inst_out[25:0], 2'b00};
`endif
            end
        end
        check("liveness", {31'b0, (deliveries > 200)}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
